div16_8_seq: RTL and testbench



---
 rtl/div16_8_seq_if.sv | 14 +
 rtl/div16_8_seq.sv | 147 ++++++++++++++
 tb/tb_div16_8_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/div16_8_seq_if.sv
// rtl/div16_8_seq_if.sv - operand/result bundle for the sequential 16/8 divider
interface div16_8_seq_if;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;

    modport master (output start, a, b, input busy, done, q, r, dz);
    modport slave  (input start, a, b, output busy, done, q, r, dz);
endinterface

// File: rtl/div16_8_seq.sv
// rtl/div16_8_seq.sv - restoring 16/8 unsigned divider, one quotient bit per cycle
// Optional: DIV16_8_ZERO_CHECK_EN short-circuits b=0 to a one-cycle completion with dz=1.
module div16_8_seq (
    input  logic              clk,
    input  logic              rst,
    div16_8_seq_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_rem;
    logic [15:0] r_quo;
    logic [3:0]  r_cnt;
    logic [15:0] r_q;
    logic [7:0]  r_r;

    logic        w_busy;
    logic        w_done;
    logic        w_last;
    logic        w_ge;
    logic        w_zero_skip;
    logic [8:0]  w_shift;
    logic [7:0]  w_rem_next;
    logic [15:0] w_quo_next;

    // The shifted value is 9 bits wide; after the conditional subtract it always fits in 8.
    assign w_shift    = {r_rem, r_a[r_cnt]};
    assign w_ge       = (w_shift >= {1'b0, r_b});
    assign w_rem_next = w_ge ? 8'(w_shift - {1'b0, r_b}) : w_shift[7:0];
    assign w_last     = (r_cnt == 4'd0);

    always_comb begin
        w_quo_next        = r_quo;
        w_quo_next[r_cnt] = w_ge;
    end

`ifdef DIV16_8_ZERO_CHECK_EN
    logic r_dz;

    assign w_zero_skip = (r_b == 8'h00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dz <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_zero_skip) begin
                r_dz <= 1'b1;
            end else if (w_last) begin
                r_dz <= 1'b0;
            end
        end
    end

    assign bus.dz = r_dz;
`else
    assign w_zero_skip = 1'b0;
    assign bus.dz      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_zero_skip || w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= 16'h0000;
            r_b   <= 8'h00;
            r_rem <= 8'h00;
            r_quo <= 16'h0000;
            r_cnt <= 4'd0;
            r_q   <= 16'h0000;
            r_r   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_rem <= 8'h00;
                        r_quo <= 16'h0000;
                        r_cnt <= 4'd15;
                    end
                end
                S_RUN: begin
                    if (w_zero_skip) begin
                        r_q <= 16'hFFFF;
                        r_r <= r_a[7:0];
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt - 4'd1;
                        if (w_last) begin
                            r_q <= w_quo_next;
                            r_r <= w_rem_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.q    = r_q;
    assign bus.r    = r_r;

endmodule

// File: tb/tb_div16_8_seq.sv
// tb/tb_div16_8_seq.sv - vector table, corner sequences and random ops against an arithmetic model
module tb_div16_8_seq;

`ifdef DIV16_8_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div16_8_seq_if bus();

    div16_8_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        int          inj;
    } vec_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] hold_q = 16'h0;
    logic [7:0]  hold_r = 8'h0;
    logic        hold_dz = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic, with the all-ones/low-byte convention for b=0.
    task automatic model(input logic [15:0] ta, input logic [7:0] tb_,
                         output logic [15:0] eq, output logic [7:0] er,
                         output logic edz, output int elat);
        if (tb_ == 8'd0) begin
            eq = 16'hFFFF;
            er = ta[7:0];
        end else begin
            eq = ta / {8'd0, tb_};
            er = 8'(ta % {8'd0, tb_});
        end
        edz  = ZC && (tb_ == 8'd0);
        elat = edz ? 1 : 16;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done falls.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [7:0] tb_,
                          input int inj_at, input logic [15:0] eq, input logic [7:0] er,
                          input logic edz, input int elat);
        int lat;
        int busy_cnt;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        check({tag, " q_hold_on_start"}, {16'd0, bus.q}, {16'd0, hold_q});
        check({tag, " r_hold_on_start"}, {24'd0, bus.r}, {24'd0, hold_r});
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            if (lat == inj_at) begin
                bus.start = 1'b1;
                bus.a     = 16'd99;
                bus.b     = 8'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, lat, elat);
        check({tag, " busy_cycles"}, busy_cnt, elat);
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " q"}, {16'd0, bus.q}, {16'd0, eq});
        check({tag, " r"}, {24'd0, bus.r}, {24'd0, er});
        check({tag, " dz"}, {31'd0, bus.dz}, {31'd0, edz});
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
        check({tag, " q_stable"}, {16'd0, bus.q}, {16'd0, eq});
        hold_q  = eq;
        hold_r  = er;
        hold_dz = edz;
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz;
        int          elat;
        logic [15:0] ra;
        logic [7:0]  rb;

        vecs.push_back('{16'd1000,  8'd7,   16'd142,   8'd6,    -1});
        vecs.push_back('{16'hFFFF,  8'hFF,  16'h0101,  8'd0,    -1});
        vecs.push_back('{16'hFFFF,  8'h01,  16'hFFFF,  8'd0,    -1});
        vecs.push_back('{16'd5,     8'd10,  16'd0,     8'd5,     8});
        vecs.push_back('{16'h1234,  8'd0,   16'hFFFF,  8'h34,   -1});
        vecs.push_back('{16'd0,     8'd1,   16'd0,     8'd0,    -1});
        vecs.push_back('{16'd255,   8'd255, 16'd1,     8'd0,    -1});
        vecs.push_back('{16'd65535, 8'd2,   16'd32767, 8'd1,    -1});
        vecs.push_back('{16'd7,     8'd200, 16'd0,     8'd7,    -1});
        vecs.push_back('{16'd4660,  8'd1,   16'd4660,  8'd0,    -1});

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a     = 16'h0;
        bus.b     = 8'h0;
        #12;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset q", {16'd0, bus.q}, 32'd0);
        check("reset r", {24'd0, bus.r}, 32'd0);
        check("reset dz", {31'd0, bus.dz}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            edz  = ZC && (vecs[i].b == 8'd0);
            elat = edz ? 1 : 16;
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].inj,
                   vecs[i].q, vecs[i].r, edz, elat);
        end

        // Abort mid-run: outputs clear asynchronously and no done follows.
        bus.start = 1'b1;
        bus.a     = 16'd500;
        bus.b     = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort q", {16'd0, bus.q}, 32'd0);
        check("abort r", {24'd0, bus.r}, 32'd0);
        check("abort dz", {31'd0, bus.dz}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 3) rst = 1'b1;
            check("abort no_done", {31'd0, bus.done}, 32'd0);
        end
        hold_q  = 16'h0;
        hold_r  = 8'h0;
        hold_dz = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op("after_reset", 16'd500, 8'd9, -1, 16'd55, 8'd5, 1'b0, 16);

        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 8'd0;
                1:       rb = 8'd1;
                2, 3, 4: rb = 8'($urandom_range(1, 15));
                default: rb = 8'($urandom);
            endcase
            model(ra, rb, eq, er, edz, elat);
            run_op($sformatf("rnd%0d a=%0h b=%0h", n, ra, rb), ra, rb, -1, eq, er, edz, elat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
